hls_main_mac_acc: RTL and testbench

//  Streaming weighted-sum stage for the tracker datapath.

---
 rtl/hls_main_mac_pkg.sv | 46 ++++
 rtl/hls_main_mac_mul.sv | 49 ++++
 rtl/hls_main_mac_acc.sv | 117 +++++++++++
 tb/tb_hls_main_mac_acc.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hls_main_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hls_main_mac_pkg
// Brief    : Shared widths, FSM encoding and saturating adder for the MAC stage.
//            sat_add is only referenced when HLS_MAIN_MAC_SATURATE_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
package hls_main_mac_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int CNT_W_DEF = 16;
    localparam int PROD_W    = 16;
    localparam int PIX_W     = 8;
    localparam int WGT_W     = 16;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Operands are sign-extended w-bit values, so the 64-bit sum cannot wrap
    // for w <= 63. Returns {overflow, clamped sum}.
    function automatic logic [64:0] sat_add(input logic signed [63:0] a,
                                            input logic signed [63:0] b,
                                            input int unsigned        w);
        logic signed [63:0] s;
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        logic               ovf;
        s   = a + b;
        mx  = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn  = -(64'sd1 <<< (w - 1));
        ovf = 1'b0;
        if (s > mx) begin
            s   = mx;
            ovf = 1'b1;
        end else if (s < mn) begin
            s   = mn;
            ovf = 1'b1;
        end
        return {ovf, s};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hls_main_mac_mul.sv
`default_nettype none
// ============================================================================
// Module   : hls_main_mac_mul
// Brief    : Stage 1 - registered u8 x s16 product truncated to s16, with
//            valid/last carried alongside.
// Revision : 1.0  initial release
// ============================================================================
module hls_main_mac_mul
    import hls_main_mac_pkg::*;
(
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              i_en,
    input  logic [PIX_W-1:0]  i_pix,
    input  logic [WGT_W-1:0]  i_wgt,
    input  logic              i_last,
    output logic              o_valid,
    output logic              o_last,
    output logic [PROD_W-1:0] o_prod
);

    logic signed [PIX_W+WGT_W:0] w_full;
    logic                        r_valid;
    logic                        r_last;
    logic [PROD_W-1:0]           r_prod;

    // Pixel is zero-extended so it multiplies as a non-negative signed value.
    assign w_full = $signed({1'b0, i_pix}) * $signed(i_wgt);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_prod  <= '0;
        end else begin
            r_valid <= i_en;
            if (i_en) begin
                r_prod <= w_full[PROD_W-1:0];
                r_last <= i_last;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_prod  = r_prod;

endmodule
`default_nettype wire

// File: rtl/hls_main_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : hls_main_mac_acc
// Brief    : Streaming weighted-sum stage: accumulates truncated pixel*weight
//            products per s_last window. Option macro: HLS_MAIN_MAC_SATURATE_EN.
// Revision : 1.0  initial release
// ============================================================================
module hls_main_mac_acc
    import hls_main_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_pix,
    input  logic [WGT_W-1:0] s_wgt,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_sum,
    output logic [CNT_W-1:0] m_count,
    output logic             m_ovf
);

    state_t                   r_state;
    state_t                   w_next;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_ovf;

    logic                     w_accept;
    logic                     w_release;
    logic                     w_s1_valid;
    logic                     w_s1_last;
    logic [PROD_W-1:0]        w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_add_ovf;

    // Gating with ap_rst keeps s_ready low for the whole reset interval.
    assign s_ready   = (r_state == ACC) && !ap_rst;
    assign w_accept  = s_valid && s_ready;
    assign w_release = (r_state == HOLD) && m_ready;

    hls_main_mac_mul u_mul (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .i_en    (w_accept),
        .i_pix   (s_pix),
        .i_wgt   (s_wgt),
        .i_last  (s_last),
        .o_valid (w_s1_valid),
        .o_last  (w_s1_last),
        .o_prod  (w_prod)
    );

    assign w_prod_ext = ACC_W'($signed(w_prod));

`ifdef HLS_MAIN_MAC_SATURATE_EN
    logic [64:0] w_sat;
    assign w_sat     = sat_add(64'($signed(r_acc)), 64'($signed(w_prod_ext)), ACC_W);
    assign w_sum     = w_sat[ACC_W-1:0];
    assign w_add_ovf = w_sat[64];
`else
    assign w_sum     = r_acc + w_prod_ext;
    assign w_add_ovf = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACC:     if (w_accept && s_last)       w_next = DRAIN;
            DRAIN:   if (w_s1_valid && w_s1_last)  w_next = HOLD;
            HOLD:    if (m_ready)                  w_next = ACC;
            default:                               w_next = ACC;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_release) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_s1_valid) begin
                    r_acc <= w_sum;
                    r_ovf <= r_ovf | w_add_ovf;
                end
                if (w_accept && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // The pipeline is empty in HOLD, so acc/cnt hold still until release.
    assign m_valid = (r_state == HOLD);
    assign m_sum   = r_acc;
    assign m_count = r_cnt;
`ifdef HLS_MAIN_MAC_SATURATE_EN
    assign m_ovf   = r_ovf;
`else
    assign m_ovf   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hls_main_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_hls_main_mac_acc
// Brief    : Directed self-checking bench for hls_main_mac_acc (32-bit and
//            16-bit accumulator instances). Honours HLS_MAIN_MAC_SATURATE_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_hls_main_mac_acc;

    logic        ap_clk = 1'b0;
    logic        ap_rst;

    logic        s_valid, s_ready, s_last;
    logic [7:0]  s_pix;
    logic [15:0] s_wgt;
    logic        m_valid, m_ready, m_ovf;
    logic [31:0] m_sum;
    logic [15:0] m_count;

    logic        s2_valid, s2_ready, s2_last;
    logic [7:0]  s2_pix;
    logic [15:0] s2_wgt;
    logic        m2_valid, m2_ready, m2_ovf;
    logic [15:0] m2_sum;
    logic [15:0] m2_count;

    int checks = 0;
    int errors = 0;

    logic signed [63:0] exp_sum4;
    logic               exp_ovf4;

    always #5 ap_clk = ~ap_clk;

    hls_main_mac_acc #(.ACC_W(32), .CNT_W(16)) dut (
        .ap_clk (ap_clk),  .ap_rst (ap_rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_pix(s_pix), .s_wgt(s_wgt), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_count(m_count), .m_ovf(m_ovf)
    );

    hls_main_mac_acc #(.ACC_W(16), .CNT_W(16)) dut16 (
        .ap_clk (ap_clk),   .ap_rst (ap_rst),
        .s_valid(s2_valid), .s_ready(s2_ready), .s_pix(s2_pix), .s_wgt(s2_wgt), .s_last(s2_last),
        .m_valid(m2_valid), .m_ready(m2_ready), .m_sum(m2_sum), .m_count(m2_count), .m_ovf(m2_ovf)
    );

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] p, input logic signed [15:0] w, input logic l);
        int n;
        s_valid = 1'b1;
        s_pix   = p;
        s_wgt   = w;
        s_last  = l;
        n = 0;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("beat_ready_timeout", 64'(s_ready), 64'sd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic collect(input string tag, input logic signed [63:0] esum, input logic signed [63:0] ecnt);
        int n;
        n = 0;
        while (!m_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 64'(m_valid), 64'sd1);
        chk({tag, "_sum"},   $signed(m_sum), esum);
        chk({tag, "_count"}, 64'(m_count), ecnt);
        chk({tag, "_ovf"},   64'(m_ovf), 64'sd0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(m_valid), 64'sd0);
        chk({tag, "_ready_back"}, 64'(s_ready), 64'sd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef HLS_MAIN_MAC_SATURATE_EN
        exp_sum4 = 64'sd32767;
        exp_ovf4 = 1'b1;
`else
        exp_sum4 = -64'sd2;
        exp_ovf4 = 1'b0;
`endif
        ap_rst   = 1'b1;
        s_valid  = 1'b0; s_pix  = '0; s_wgt  = '0; s_last  = 1'b0; m_ready  = 1'b0;
        s2_valid = 1'b0; s2_pix = '0; s2_wgt = '0; s2_last = 1'b0; m2_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(m_valid), 64'sd0);
        chk("rst_ready", 64'(s_ready), 64'sd0);
        ap_rst = 1'b0;
        tick();
        chk("init_ready", 64'(s_ready), 64'sd1);
        chk("init_sum",   $signed(m_sum), 64'sd0);
        chk("init_count", 64'(m_count), 64'sd0);

        // Window 1: 10*(3-5+100+1) = 990, result two cycles after last accept
        beat(8'd10, 16'sd3, 1'b0);
        beat(8'd10, -16'sd5, 1'b0);
        beat(8'd10, 16'sd100, 1'b0);
        beat(8'd10, 16'sd1, 1'b1);
        chk("t1_lat1_valid", 64'(m_valid), 64'sd0);
        chk("t1_lat1_ready", 64'(s_ready), 64'sd0);
        tick();
        chk("t1_lat2_valid", 64'(m_valid), 64'sd1);
        collect("t1", 64'sd990, 64'sd4);

        // 255*300 = 76500, low 16 bits = 10964
        beat(8'd255, 16'sd300, 1'b1);
        collect("t2", 64'sd10964, 64'sd1);

        // Result held under backpressure while s_valid presents garbage
        beat(8'd3, 16'sd2, 1'b1);
        tick();
        s_valid = 1'b1; s_pix = 8'd200; s_wgt = 16'sd50;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_ready", 64'(s_ready), 64'sd0);
            chk("t3_hold_sum",   $signed(m_sum), 64'sd6);
        end
        s_valid = 1'b0;
        collect("t3a", 64'sd6, 64'sd1);
        beat(8'd1, 16'sd7, 1'b0);
        beat(8'd1, 16'sd7, 1'b1);
        collect("t3b", 64'sd14, 64'sd2);

        // 16-bit accumulator: 32767 + 32767
        s2_valid = 1'b1; s2_pix = 8'd1; s2_wgt = 16'sd32767; s2_last = 1'b0;
        tick();
        s2_last = 1'b1;
        tick();
        s2_valid = 1'b0; s2_last = 1'b0;
        tick();
        chk("t4_valid", 64'(m2_valid), 64'sd1);
        chk("t4_sum",   $signed(m2_sum), exp_sum4);
        chk("t4_count", 64'(m2_count), 64'sd2);
        chk("t4_ovf",   64'(m2_ovf), 64'(exp_ovf4));
        m2_ready = 1'b1;
        tick();
        m2_ready = 1'b0;
        chk("t4_valid_drop", 64'(m2_valid), 64'sd0);
        chk("t4_ovf_clear",  64'(m2_ovf), 64'sd0);

        // Reset mid-window drops the partial sum; async assertion checked mid-cycle
        beat(8'd9, 16'sd9, 1'b0);
        beat(8'd9, 16'sd9, 1'b0);
        ap_rst = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(m_valid), 64'sd0);
        chk("t5_rst_sum",   $signed(m_sum), 64'sd0);
        chk("t5_rst_count", 64'(m_count), 64'sd0);
        chk("t5_rst_ready", 64'(s_ready), 64'sd0);
        chk("t5_rst_ovf",   64'(m_ovf), 64'sd0);
        tick();
        ap_rst = 1'b0;
        tick();
        chk("t5_ready", 64'(s_ready), 64'sd1);
        beat(8'd2, 16'sd5, 1'b0);
        beat(8'd2, 16'sd5, 1'b0);
        beat(8'd2, 16'sd5, 1'b1);
        collect("t5", 64'sd30, 64'sd3);

        // s_valid toggling with junk on idle cycles
        for (int i = 0; i < 6; i++) begin
            beat(8'd4, -16'sd1, (i == 5));
            if (i < 5) begin
                s_pix = 8'd99;
                s_wgt = 16'sd77;
                tick();
            end
        end
        collect("t6", -64'sd24, 64'sd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
